// File: rtl/multicycle_controller.sv
// multicycle_controller: control FSM for the multicycle RISC-V core.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB. It waits on a
// variable-latency memory through mem_ready. It traps on an illegal opcode,
// and on a memory wait that reaches MEM_TIMEOUT cycles (MEM_TIMEOUT=0 turns
// the timeout off).
// Optional feature: define MC_PERF_CNT_EN to build the retired-instruction
// counter (instret). When it is undefined, instret is tied to 0.
//
// state  | meaning
// FETCH  | instruction read; ir_write pulses when mem_ready arrives
// DECODE | latch opcode, check legality
// EXEC   | ALU op; branches/jumps retire here
// MEM    | data access for LW/SW; SW retires when mem_ready arrives
// WB     | register write-back and PC update
// TRAP   | halted; only reset leaves
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             alu_src,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             branch,
  output logic             jsel,
  output logic [1:0]       alu_op,
  output logic [2:0]       state,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jsel;
    logic [1:0] alu_op;
    logic       trap;
  } ctrl_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  // The wait counter only has to hold 0..MEM_TIMEOUT-1. The limit is hit on
  // the MEM_TIMEOUT-th consecutive stall cycle.
  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  // Reset leaves the core in FETCH, so only mem_read is high.
  localparam ctrl_t CTRL_RST = '{pc_write: 1'b0, alu_src: 1'b0, mem_to_reg: 1'b0,
                                 reg_write: 1'b0, mem_read: 1'b1, mem_write: 1'b0,
                                 branch: 1'b0, jsel: 1'b0, alu_op: 2'b00, trap: 1'b0};

  state_e            state_q, state_d;
  logic [6:0]        opc_q, opc_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [1:0]        cause_q, cause_d;
  ctrl_t             ctrl_q, ctrl_d;
  logic              legal, wait_hit, imm_sel, sw_done;
  logic [1:0]        alu_op_dec;

  assign legal    = opcode inside {OP_R, OP_I, OP_LUI, OP_LW, OP_SW, OP_BR, OP_JAL, OP_JALR};
  // mem_ready on the limit cycle wins: the hit only counts while still stalled.
  assign wait_hit = (MEM_TIMEOUT != 0) && !mem_ready && (wait_q == WAIT_LIM);

  // Next state, opcode latch, stall counter and trap cause
  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    wait_d  = '0;
    cause_d = cause_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (wait_hit) begin
          state_d = S_TRAP;
          cause_d = 2'b10;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        opc_d = opcode;
        if (legal) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_TRAP;
          cause_d = 2'b01;
        end
      end
      S_EXEC: begin
        case (opc_q)
          OP_BR, OP_JAL, OP_JALR: state_d = S_FETCH;
          OP_LW, OP_SW:           state_d = S_MEM;
          default:                state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          state_d = (opc_q == OP_LW) ? S_WB : S_FETCH;
        end else if (wait_hit) begin
          state_d = S_TRAP;
          cause_d = 2'b10;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WB:    state_d = S_FETCH;
      S_TRAP:  state_d = S_TRAP;
      default: begin
        state_d = S_TRAP;
        cause_d = 2'b01;
      end
    endcase
  end

  // ALU operand select and ALU op class for the opcode being carried forward
  always_comb begin
    imm_sel    = 1'b0;
    alu_op_dec = 2'b00;
    case (opc_d)
      OP_R:                  alu_op_dec = 2'b10;
      OP_I: begin
        imm_sel    = 1'b1;
        alu_op_dec = 2'b10;
      end
      OP_LUI: begin
        imm_sel    = 1'b1;
        alu_op_dec = 2'b11;
      end
      OP_LW, OP_SW, OP_JALR: imm_sel = 1'b1;
      OP_BR:                 alu_op_dec = 2'b01;
      default: ;
    endcase
  end

  // Moore controls for the state being entered, so the outputs come out of flops
  always_comb begin
    ctrl_d = '0;
    case (state_d)
      S_FETCH: ctrl_d.mem_read = 1'b1;
      S_EXEC: begin
        ctrl_d.alu_src = imm_sel;
        ctrl_d.alu_op  = alu_op_dec;
        case (opc_d)
          OP_BR: begin
            ctrl_d.branch   = 1'b1;
            ctrl_d.pc_write = 1'b1;
          end
          OP_JAL, OP_JALR: begin
            ctrl_d.jsel      = 1'b1;
            ctrl_d.reg_write = 1'b1;
            ctrl_d.pc_write  = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        if (opc_d == OP_LW) begin
          ctrl_d.mem_read = 1'b1;
        end else begin
          ctrl_d.mem_write = 1'b1;
          ctrl_d.alu_src   = 1'b1;
        end
      end
      S_WB: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.pc_write   = 1'b1;
        ctrl_d.mem_to_reg = (opc_d == OP_LW);
        ctrl_d.alu_src    = imm_sel;
        ctrl_d.alu_op     = alu_op_dec;
      end
      S_TRAP:  ctrl_d.trap = 1'b1;
      default: ;
    endcase
  end

  // FSM state, latched opcode, stall counter, trap cause and registered controls
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      opc_q   <= '0;
      wait_q  <= '0;
      cause_q <= '0;
      ctrl_q  <= CTRL_RST;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      wait_q  <= wait_d;
      cause_q <= cause_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // The two handshake strobes follow mem_ready directly. They are gated by
  // reset so that no partial strobe appears while reset is asserted.
  assign sw_done  = (state_q == S_MEM) && (opc_q == OP_SW) && mem_ready && !reset;
  assign ir_write = (state_q == S_FETCH) && mem_ready && !reset;
  assign pc_write = ctrl_q.pc_write | sw_done;

  assign alu_src    = ctrl_q.alu_src;
  assign mem_to_reg = ctrl_q.mem_to_reg;
  assign reg_write  = ctrl_q.reg_write;
  assign mem_read   = ctrl_q.mem_read;
  assign mem_write  = ctrl_q.mem_write;
  assign branch     = ctrl_q.branch;
  assign jsel       = ctrl_q.jsel;
  assign alu_op     = ctrl_q.alu_op;
  assign trap       = ctrl_q.trap;
  assign trap_cause = cause_q;
  assign state      = state_q;

`ifdef MC_PERF_CNT_EN
  logic [CNT_W-1:0] instret_q, instret_d;

  // Retired-instruction count: one per pc_write. It wraps, and a trap does not clear it.
  always_comb instret_d = pc_write ? instret_q + CNT_W'(1) : instret_q;

  // Counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) instret_q <= '0;
    else       instret_q <= instret_d;
  end

  assign instret = instret_q;
`else
  assign instret = '0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller. The reference model tracks each instruction
// as a list of remaining phases. The list is expanded at decode from the
// instruction class. An instruction retires when its last phase completes.
// Memory phases complete only when mem_ready is high.
module tb_multicycle_controller;

  localparam int MEM_TO = 4;
  localparam int CW     = 4;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  localparam int P_FETCH = 0, P_DECODE = 1, P_EXEC = 2, P_MEM = 3, P_WB = 4, P_TRAP = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [6:0]    opcode;
  logic          mem_ready;
  logic          pc_write, ir_write, alu_src, mem_to_reg, reg_write;
  logic          mem_read, mem_write, branch, jsel, trap;
  logic [1:0]    alu_op, trap_cause;
  logic [2:0]    state;
  logic [CW-1:0] instret;

  always #5 clk = ~clk;

  multicycle_controller #(.MEM_TIMEOUT(MEM_TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .alu_src(alu_src),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .branch(branch), .jsel(jsel), .alu_op(alu_op),
    .state(state), .trap(trap), .trap_cause(trap_cause), .instret(instret)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int         ph_q[$];
  bit         m_trap;
  int         m_cause, m_stall, m_retired;
  logic [6:0] m_opc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  function automatic bit is_legal(input logic [6:0] o);
    return o inside {OP_R, OP_I, OP_LUI, OP_LW, OP_SW, OP_BR, OP_JAL, OP_JALR};
  endfunction

  function automatic bit uses_imm(input logic [6:0] o);
    return o inside {OP_I, OP_LUI, OP_LW, OP_SW, OP_JALR};
  endfunction

  function automatic logic [1:0] alu_class(input logic [6:0] o);
    if (o == OP_LUI) return 2'b11;
    if (o == OP_R || o == OP_I) return 2'b10;
    if (o == OP_BR) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [31:0] exp_cnt(input int n);
`ifdef MC_PERF_CNT_EN
    return 32'(n % (1 << CW));
`else
    return 32'(n * 0);
`endif
  endfunction

  function automatic logic [6:0] pick_opc();
    if ($urandom_range(0, 11) == 0) return 7'($urandom);
    case ($urandom_range(0, 7))
      0:       return OP_R;
      1:       return OP_I;
      2:       return OP_LUI;
      3:       return OP_LW;
      4:       return OP_SW;
      5:       return OP_BR;
      6:       return OP_JAL;
      default: return OP_JALR;
    endcase
  endfunction

  task automatic model_reset();
    ph_q.delete();
    ph_q.push_back(P_FETCH);
    ph_q.push_back(P_DECODE);
    m_trap = 0; m_cause = 0; m_stall = 0; m_retired = 0; m_opc = '0;
  endtask

  task automatic model_step(input logic [6:0] opc, input bit rdy);
    int ph;
    if (m_trap) return;
    ph = ph_q[0];
    if ((ph == P_FETCH || ph == P_MEM) && !rdy) begin
      m_stall++;
      if (MEM_TO != 0 && m_stall == MEM_TO) begin
        m_trap = 1; m_cause = 2;
      end
      return;
    end
    m_stall = 0;
    void'(ph_q.pop_front());
    if (ph == P_DECODE) begin
      m_opc = opc;
      if (!is_legal(opc)) begin
        m_trap = 1; m_cause = 1;
      end else if (opc == OP_BR || opc == OP_JAL || opc == OP_JALR) begin
        ph_q.push_back(P_EXEC);
      end else if (opc == OP_LW) begin
        ph_q.push_back(P_EXEC); ph_q.push_back(P_MEM); ph_q.push_back(P_WB);
      end else if (opc == OP_SW) begin
        ph_q.push_back(P_EXEC); ph_q.push_back(P_MEM);
      end else begin
        ph_q.push_back(P_EXEC); ph_q.push_back(P_WB);
      end
    end else if (ph_q.size() == 0) begin
      m_retired++;
      ph_q.push_back(P_FETCH);
      ph_q.push_back(P_DECODE);
    end
  endtask

  task automatic compare_all(input string pfx);
    int         ph;
    bit         done, ex, wb, mem, lw, sw, jmp, e_pc, e_ir;
    logic [8:0] e_ctrl, o_ctrl;
    if (m_trap) ph = P_TRAP;
    else        ph = ph_q[0];
    ex   = (ph == P_EXEC);
    wb   = (ph == P_WB);
    mem  = (ph == P_MEM);
    lw   = (m_opc == OP_LW);
    sw   = (m_opc == OP_SW);
    jmp  = (m_opc == OP_JAL || m_opc == OP_JALR);
    done = !((ph == P_FETCH || ph == P_MEM) && !mem_ready);
    e_pc = !reset && !m_trap && ph != P_DECODE && ph_q.size() == 1 && done;
    e_ir = !reset && ph == P_FETCH && mem_ready;
    e_ctrl = {((ex || wb) && uses_imm(m_opc)) || (mem && sw),
              wb && lw,
              (ex && jmp) || wb,
              (ph == P_FETCH) || (mem && lw),
              mem && sw,
              ex && (m_opc == OP_BR),
              ex && jmp,
              (ex || wb) ? alu_class(m_opc) : 2'b00};
    o_ctrl = {alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, jsel, alu_op};
    check({pfx, ".state"},      32'(state),      32'(ph));
    check({pfx, ".ctrl"},       32'(o_ctrl),     32'(e_ctrl));
    check({pfx, ".pc_write"},   32'(pc_write),   32'(e_pc));
    check({pfx, ".ir_write"},   32'(ir_write),   32'(e_ir));
    check({pfx, ".trap"},       32'(trap),       32'(m_trap));
    check({pfx, ".trap_cause"}, 32'(trap_cause), 32'(m_cause));
    check({pfx, ".instret"},    32'(instret),    exp_cnt(m_retired));
  endtask

  // Entered just after a rising edge; leaves just after the next one.
  task automatic step(input logic [6:0] opc, input bit rdy);
    opcode    = opc;
    mem_ready = rdy;
    @(negedge clk);
    compare_all("cyc");
    @(posedge clk);
    model_step(opc, rdy);
    #1;
  endtask

  // Asserts reset mid-cycle to exercise the asynchronous path, then releases it.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    compare_all("rst");
    @(posedge clk);
    #1;
    compare_all("rst_hold");
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; opcode = '0; mem_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("por");
    reset = 1'b0;

    // R-type, no stalls: 4 cycles, retire once
    repeat (4) step(OP_R, 1'b1);
    check("r_state", 32'(state), 32'd0);
    check("r_instret", 32'(instret), exp_cnt(1));

    // LW with 3 stall cycles in MEM: 8 cycles
    repeat (3) step(OP_LW, 1'b1);
    repeat (3) step(OP_LW, 1'b0);
    repeat (2) step(OP_LW, 1'b1);
    check("lw_state", 32'(state), 32'd0);
    check("lw_instret", 32'(instret), exp_cnt(2));

    // Remaining classes, no stalls
    repeat (4) step(OP_SW, 1'b1);
    repeat (3) step(OP_BR, 1'b1);
    repeat (3) step(OP_JAL, 1'b1);
    repeat (3) step(OP_JALR, 1'b1);
    repeat (4) step(OP_I, 1'b1);
    repeat (4) step(OP_LUI, 1'b1);
    check("mix_instret", 32'(instret), exp_cnt(8));

    // Illegal opcode traps and stays halted
    step(OP_R, 1'b1);
    step(7'b1111111, 1'b1);
    for (int i = 0; i < 20; i++) step(7'($urandom), 1'($urandom));
    check("ill_trap", 32'(trap), 32'd1);
    check("ill_cause", 32'(trap_cause), 32'd1);

    // Fetch timeout after MEM_TO stall cycles, then the rescue case
    do_reset();
    repeat (MEM_TO) step(OP_R, 1'b0);
    check("to_state", 32'(state), 32'd5);
    check("to_cause", 32'(trap_cause), 32'd2);
    do_reset();
    repeat (MEM_TO - 1) step(OP_R, 1'b0);
    step(OP_R, 1'b1);
    check("to_rescue_state", 32'(state), 32'd1);

    // Data-side timeout on LW
    do_reset();
    repeat (3) step(OP_LW, 1'b1);
    repeat (MEM_TO) step(OP_LW, 1'b0);
    check("to_mem_cause", 32'(trap_cause), 32'd2);

    // Reset during SW in MEM, then a normal instruction
    do_reset();
    repeat (4) step(OP_R, 1'b1);
    repeat (3) step(OP_SW, 1'b1);
    step(OP_SW, 1'b0);
    mem_ready = 1'b1;
    do_reset();
    check("swrst_mem_write", 32'(mem_write), 32'd0);
    check("swrst_instret", 32'(instret), 32'd0);
    repeat (4) step(OP_R, 1'b1);
    check("swrst_resume", 32'(instret), exp_cnt(1));

    // 17 branches: counter wraps at CNT_W bits
    do_reset();
    repeat (17 * 3) step(OP_BR, 1'b1);
    check("wrap_instret", 32'(instret), exp_cnt(17));

    // Randomized run: garbage opcode outside DECODE, random stalls and resets
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0 || (m_trap && $urandom_range(0, 3) == 0)) begin
        do_reset();
      end else if (!m_trap && ph_q[0] == P_DECODE) begin
        step(pick_opc(), 1'($urandom_range(0, 3) != 0));
      end else begin
        step(7'($urandom), 1'($urandom_range(0, 3) != 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control FSM for the multicycle RISC-V core, successor to the single-cycle opcode decoder. It sequences each instruction through fetch, decode, execute, memory and write-back states, and handshakes with a variable-latency memory through `mem_ready`. Illegal opcodes and memory stalls that exceed a programmable bound trap the core. It sits between the instruction register and the datapath muxes, register file, PC and memory enables.

## Interface
- `MEM_TIMEOUT`, default 16: maximum cycles spent waiting on `mem_ready` in one access; 0 disables the timeout.
- `CNT_W`, default 32: width of the retired-instruction counter.
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `opcode`  in  7  `instr[6:0]` from the instruction register; valid from DECODE onward.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `pc_write`  out  1  PC update strobe; one pulse per retired instruction.
- `ir_write`  out  1  instruction register load strobe.
- `alu_src`, `mem_to_reg`, `reg_write`, `mem_read`, `mem_write`, `branch`, `jsel`  out  1 each  datapath controls, same meanings as the single-cycle decoder.
- `alu_op`  out  2  00 LW/SW/JAL/JALR, 01 branch, 10 R/I, 11 LUI.
- `state`  out  3  current state encoding, for debug.
- `trap`  out  1  core halted.
- `trap_cause`  out  2  01 illegal opcode, 10 memory timeout, 00 none.
- `instret`  out  CNT_W  retired-instruction count.

## Operation
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Codes 6 and 7 go to TRAP with cause 01.
- Legal opcodes: 0110011 (R), 0010011 (I), 0110111 (LUI), 0000011 (LW), 0100011 (SW), 1100011 (BR), 1101111 (JAL), 1100111 (JALR).
- **FETCH**
  - `mem_read`=1.
  - On `mem_ready`: `ir_write`=1 for that cycle (combinational, gated by `!reset`), then go to DECODE.
- **DECODE**
  - Register `opcode` into `opc_q`.
  - Illegal opcode: go to TRAP with cause 01. Otherwise go to EXEC.
- **EXEC**
  - `alu_src` and `alu_op` are decoded from `opc_q`.
  - BR: `branch`=1, `pc_write`=1, then FETCH.
  - JAL/JALR: `jsel`=1, `reg_write`=1, `pc_write`=1, then FETCH.
  - LW/SW: go to MEM.
  - R/I/LUI: go to WB.
- **MEM**
  - LW: hold `mem_read`=1 until `mem_ready`, then go to WB.
  - SW: hold `mem_write`=1 and `alu_src`=1 until `mem_ready`. On that cycle `pc_write`=1, then FETCH.
- **WB**
  - `reg_write`=1 and `pc_write`=1, then FETCH.
  - `mem_to_reg`=1 only for LW.
  - `alu_src` and `alu_op` are held from EXEC.
- **TRAP**
  - All control outputs are 0 and `trap`=1.
  - The cause is latched. Only `reset` exits TRAP.
- **Timeout**
  - A wait counter clears on entry to FETCH or MEM and increments each cycle that `mem_ready`=0.
  - When the counter equals `MEM_TIMEOUT` (and `MEM_TIMEOUT`≠0), the next state is TRAP with cause 10. The pending access is abandoned and no strobe is issued.
  - `mem_ready`=1 in the same cycle that the counter reaches the limit wins: the access completes normally.
- **instret**
  - Increments on every `pc_write` cycle.
  - Wraps modulo 2^CNT_W. It is not cleared by a trap.

## Timing
- Reset values: `state`=FETCH, `mem_read`=1, `trap_cause`=00, `instret`=0. All other outputs are 0.
- Reset mid-instruction returns the FSM to FETCH asynchronously. No partial strobe survives.
- All outputs are Moore (decoded from `state`/`opc_q`), except `ir_write`, and `pc_write` in MEM for SW, which are qualified by `mem_ready`.
- Minimum latency with `mem_ready` held at 1, in cycles per instruction:
  - BR, JAL, JALR: 3.
  - R, I, LUI: 4.
  - SW: 4.
  - LW: 5.
- Each cycle with `mem_ready`=0 adds one cycle.
- `opcode` changes outside DECODE are ignored.

## Configuration
- `MC_PERF_CNT_EN` defined: `instret` counter is implemented as described above.
- `MC_PERF_CNT_EN` undefined: no counter logic is built and `instret` is tied to 0.
- FSM behaviour is identical with and without the macro.

## Test plan
- `mem_ready`=1 constant, opcode 0110011 → states 0,1,2,4 then 0; `reg_write`=1 only in WB; `instret`=1 after the first `pc_write`.
- LW with `mem_ready` low for 3 MEM cycles → `mem_read` held for 4 cycles; WB shows `mem_to_reg`=1; 8 cycles total.
- Opcode 1111111 → DECODE goes to TRAP; `trap`=1, `trap_cause`=01; outputs stay 0 for 20 further cycles.
- `MEM_TIMEOUT`=4, `mem_ready`=0 in FETCH → TRAP after 4 wait cycles, cause 10, `ir_write` never asserted; rerun with `mem_ready`=1 on the 4th wait cycle → DECODE, no trap.
- Reset asserted in MEM during SW → `state`=0 immediately, `mem_write`=0, `instret`=0; normal fetch resumes after reset release.
- With `MC_PERF_CNT_EN` defined and `CNT_W`=4, 17 retired BR instructions → `instret`=1 (wrap); without the macro `instret`=0 throughout.
